// File: rtl/pipe_stage_buffer.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer, synchronous flush
// and saturating stall/bubble counters. Empty slots are presented as zero-data bubbles.
module pipe_stage_buffer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]  stall_count,
    output logic [CNT_WIDTH-1:0]  bubble_count
);

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic [CNT_WIDTH-1:0]  stall_q;
    logic [CNT_WIDTH-1:0]  bubble_q;
    logic                  acc;
    logic                  take;

    // Handshake outputs depend only on registered state, so out_ready never reaches in_ready.
    always_comb begin
        out_valid = (state_q != StEmpty);
        in_ready  = (state_q != StTwo);
        acc       = in_valid && in_ready;
        take      = out_valid && out_ready;
        out_data  = main_q;
        case (state_q)
            StOne:   occupancy = 2'd1;
            StTwo:   occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (acc) begin
                        main_q  <= in_data;
                        state_q <= StOne;
                    end
                end
                StOne: begin
                    if (acc && take) begin
                        main_q <= in_data;
                    end else if (acc) begin
                        skid_q  <= in_data;
                        state_q <= StTwo;
                    end else if (take) begin
                        main_q  <= '0;
                        state_q <= StEmpty;
                    end
                end
                StTwo: begin
                    // The skid entry is younger, so it moves up into main on a take.
                    if (take) begin
                        main_q  <= skid_q;
                        skid_q  <= '0;
                        state_q <= StOne;
                    end
                end
                default: begin
                    main_q  <= '0;
                    skid_q  <= '0;
                    state_q <= StEmpty;
                end
            endcase
        end
    end

    // Counters keep running through flush cycles; only reset clears them.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (out_ready && !out_valid && (bubble_q != '1)) begin
                bubble_q <= bubble_q + 1'b1;
            end
        end
    end

    assign stall_count  = stall_q;
    assign bubble_count = bubble_q;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed, table-driven bench for pipe_stage_buffer, plus a small-counter instance for the
// saturation sequence.
module tb_pipe_stage_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;
    logic [1:0]  occupancy;
    logic [15:0] stall_count;
    logic [15:0] bubble_count;

    logic        s_reset;
    logic        s_flush;
    logic        s_in_valid;
    logic [15:0] s_in_data;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [15:0] s_out_data;
    logic        s_out_ready;
    logic [1:0]  s_occupancy;
    logic [3:0]  s_stall_count;
    logic [3:0]  s_bubble_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipe_stage_buffer dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .occupancy    (occupancy),
        .stall_count  (stall_count),
        .bubble_count (bubble_count)
    );

    pipe_stage_buffer #(
        .DATA_WIDTH (16),
        .CNT_WIDTH  (4)
    ) dut_sat (
        .clock        (clock),
        .reset        (s_reset),
        .flush        (s_flush),
        .in_valid     (s_in_valid),
        .in_data      (s_in_data),
        .in_ready     (s_in_ready),
        .out_valid    (s_out_valid),
        .out_data     (s_out_data),
        .out_ready    (s_out_ready),
        .occupancy    (s_occupancy),
        .stall_count  (s_stall_count),
        .bubble_count (s_bubble_count)
    );

    // Inputs applied before an edge and the outputs expected just after that edge.
    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [63:0] d;
        logic        ordy;
        logic        e_ov;
        logic [63:0] e_od;
        logic        e_ir;
        logic [1:0]  e_occ;
        logic [15:0] e_stall;
        logic [15:0] e_bub;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic rst, input logic fl, input logic iv,
                               input logic [63:0] d, input logic ordy, input logic e_ov,
                               input logic [63:0] e_od, input logic e_ir,
                               input logic [1:0] e_occ, input logic [15:0] e_stall,
                               input logic [15:0] e_bub);
        vec_t r;
        r.rst = rst; r.fl = fl; r.iv = iv; r.d = d; r.ordy = ordy;
        r.e_ov = e_ov; r.e_od = e_od; r.e_ir = e_ir; r.e_occ = e_occ;
        r.e_stall = e_stall; r.e_bub = e_bub;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        s_reset = 1'b1; s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;

        //          rst fl iv data      ordy  ov od        ir occ stall bub
        // reset with a transfer offered: nothing captured
        vecs.push_back(v(1, 0, 1, 64'hAAAA, 0,  0, 64'h0,    1, 0, 0, 0));
        vecs.push_back(v(1, 0, 1, 64'hAAAA, 0,  0, 64'h0,    1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 64'h0,    0,  0, 64'h0,    1, 0, 0, 0));
        // streaming
        vecs.push_back(v(0, 0, 1, 64'h1,    1,  1, 64'h1,    1, 1, 0, 1));
        vecs.push_back(v(0, 0, 1, 64'h2,    1,  1, 64'h2,    1, 1, 0, 1));
        vecs.push_back(v(0, 0, 1, 64'h3,    1,  1, 64'h3,    1, 1, 0, 1));
        vecs.push_back(v(0, 0, 0, 64'h0,    1,  0, 64'h0,    1, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 64'h0,    1,  0, 64'h0,    1, 0, 0, 2));
        // back-pressure, then drain in order
        vecs.push_back(v(0, 0, 1, 64'h10,   0,  1, 64'h10,   1, 1, 0, 2));
        vecs.push_back(v(0, 0, 1, 64'h11,   0,  1, 64'h10,   0, 2, 1, 2));
        vecs.push_back(v(0, 0, 1, 64'h12,   0,  1, 64'h10,   0, 2, 2, 2));
        vecs.push_back(v(0, 0, 1, 64'h12,   1,  1, 64'h11,   1, 1, 2, 2));
        vecs.push_back(v(0, 0, 1, 64'h12,   1,  1, 64'h12,   1, 1, 2, 2));
        vecs.push_back(v(0, 0, 0, 64'h0,    1,  0, 64'h0,    1, 0, 2, 2));
        vecs.push_back(v(0, 0, 0, 64'h0,    0,  0, 64'h0,    1, 0, 2, 2));
        // flush in TWO with a same-cycle offer of 0x99
        vecs.push_back(v(0, 0, 1, 64'h20,   0,  1, 64'h20,   1, 1, 2, 2));
        vecs.push_back(v(0, 0, 1, 64'h21,   0,  1, 64'h20,   0, 2, 3, 2));
        vecs.push_back(v(0, 1, 1, 64'h99,   0,  0, 64'h0,    1, 0, 4, 2));
        vecs.push_back(v(0, 0, 0, 64'h0,    0,  0, 64'h0,    1, 0, 4, 2));
        // flush in ONE with accept and take in the same cycle
        vecs.push_back(v(0, 0, 1, 64'h30,   1,  1, 64'h30,   1, 1, 4, 3));
        vecs.push_back(v(0, 1, 1, 64'h31,   1,  0, 64'h0,    1, 0, 4, 3));
        // reset in TWO with out_ready high
        vecs.push_back(v(0, 0, 1, 64'h40,   0,  1, 64'h40,   1, 1, 4, 3));
        vecs.push_back(v(0, 0, 1, 64'h41,   0,  1, 64'h40,   0, 2, 5, 3));
        vecs.push_back(v(1, 0, 0, 64'h0,    1,  0, 64'h0,    1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 64'h0,    0,  0, 64'h0,    1, 0, 0, 0));

        foreach (vecs[i]) begin
            @(negedge clock);
            reset     = vecs[i].rst;
            flush     = vecs[i].fl;
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            @(posedge clock);
            #1;
            check($sformatf("v%0d out_valid", i), {63'b0, out_valid}, {63'b0, vecs[i].e_ov});
            check($sformatf("v%0d out_data", i), out_data, vecs[i].e_od);
            check($sformatf("v%0d in_ready", i), {63'b0, in_ready}, {63'b0, vecs[i].e_ir});
            check($sformatf("v%0d occupancy", i), {62'b0, occupancy}, {62'b0, vecs[i].e_occ});
            check($sformatf("v%0d stall_count", i), {48'b0, stall_count},
                  {48'b0, vecs[i].e_stall});
            check($sformatf("v%0d bubble_count", i), {48'b0, bubble_count},
                  {48'b0, vecs[i].e_bub});
        end

        // Saturation: one entry held with out_ready low for 20 cycles on a 4-bit counter.
        @(negedge clock);
        @(negedge clock);
        s_reset     = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 16'h5A5A;
        s_out_ready = 1'b0;
        @(negedge clock);
        s_in_valid = 1'b0;
        check("sat initial stall_count", {60'b0, s_stall_count}, 64'h0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            #1;
            check($sformatf("sat stall_count k=%0d", k), {60'b0, s_stall_count},
                  (k > 15) ? 64'hF : 64'(k));
        end
        check("sat out_data held", {48'b0, s_out_data}, 64'h5A5A);
        check("sat bubble_count", {60'b0, s_bubble_count}, 64'h0);
        check("sat occupancy", {62'b0, s_occupancy}, 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buffer.md
# pipe_stage_buffer

Parametrised pipeline stage register with a valid/ready handshake, a one-entry skid buffer, synchronous flush and saturating stall/bubble counters. It sits between any two core pipeline stages (IF→ID, ID→EX, EX→MEM, MEM→WB) in place of a bare stage latch. It decouples back-pressure so stalls no longer need a global stall vector, and empty slots are presented as zero-data bubbles.

## Interface
- DATA_WIDTH, 64, payload width (e.g. {pc, instruction}).
- CNT_WIDTH, 16, width of each performance counter.

- clock  input  1  stage clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- flush  input  1  synchronous discard of all held entries.
- in_valid  input  1  upstream presents a payload.
- in_data  input  DATA_WIDTH  upstream payload.
- in_ready  output  1  block can accept; a transfer occurs when in_valid & in_ready.
- out_valid  output  1  payload presented downstream.
- out_data  output  DATA_WIDTH  downstream payload; all zero when out_valid=0.
- out_ready  input  1  downstream accepts; a transfer occurs when out_valid & out_ready.
- occupancy  output  2  number of held entries (0, 1 or 2).
- stall_count  output  CNT_WIDTH  cycles with out_valid & !out_ready; saturating.
- bubble_count  output  CNT_WIDTH  cycles with out_ready & !out_valid; saturating.

## Operation
- Storage: main register (drives out_data) and skid register, each DATA_WIDTH bits.
- State machine:
  - EMPTY: occupancy 0.
  - ONE: main valid, occupancy 1.
  - TWO: main and skid valid, occupancy 2.
- Derived outputs:
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO). It is a pure function of registered state, with no combinational path from out_ready.
- Transitions, with acc = in_valid & in_ready and take = out_valid & out_ready:
  - EMPTY, acc: main <= in_data; go to ONE.
  - EMPTY, !acc: stay; main holds zero.
  - ONE, acc & take: main <= in_data; stay in ONE.
  - ONE, acc & !take: skid <= in_data; go to TWO.
  - ONE, !acc & take: main <= 0; go to EMPTY. The bubble is zero data.
  - ONE, !acc & !take: hold.
  - TWO, take: main <= skid; skid <= 0; go to ONE. No accept is possible, since in_ready=0.
  - TWO, !take: hold.
- Ordering is strictly FIFO. The skid entry is always younger than the main entry.
- Priority: reset > flush > normal operation.
- Flush:
  - State goes to EMPTY and main and skid go to zero.
  - Any same-cycle acc is discarded. Any same-cycle take is still counted as consumed by downstream; the bench ignores it.
  - Counters are not cleared by flush.
- Counters:
  - Increment on the rising edge when their condition held in that cycle.
  - Saturate at all-ones. No wrap.
  - They count during flush cycles but not while reset is asserted.
- Data is never modified; width is passed through unchanged.

## Timing
- Reset values:
  - state EMPTY, main and skid 0.
  - out_valid 0, out_data 0, occupancy 0.
  - in_ready 1. Transfers offered while reset is high are dropped.
  - stall_count 0, bubble_count 0.
- Latency: a payload accepted at edge N appears on out_data with out_valid=1 after edge N, i.e. 1 cycle.
- Throughput: one transfer per cycle sustained while out_ready=1.
- Back-pressure:
  - One extra payload is absorbed after out_ready falls.
  - in_ready falls the cycle after the skid fills.
  - in_ready rises the cycle after the first take from TWO.
- Reset or flush mid-operation: effective at the edge. The next cycle shows out_valid=0, out_data=0, in_ready=1.

## Test plan
- Reset with in_valid=1 and in_data=0xAAAA held → after reset deasserts: out_valid=0, out_data=0, in_ready=1, counters 0. Nothing was captured.
- Streaming: out_ready=1, inputs 0x1, 0x2, 0x3 on consecutive cycles → out_data 0x1, 0x2, 0x3 one cycle later each; occupancy stays 1; then in_valid=0 gives out_valid=0, out_data=0, and bubble_count increments.
- Back-pressure: out_ready=0, offer 0x10, 0x11, 0x12 back-to-back →
  - 0x10 in main, 0x11 in skid; in_ready=0 and occupancy=2 after the second accept; 0x12 held upstream.
  - out_ready=1 then drains 0x10, 0x11, 0x12 in order.
  - stall_count equals the number of cycles out_valid&!out_ready.
- Flush in TWO with in_valid=1 and in_data=0x99 the same cycle → next cycle out_valid=0, occupancy=0, in_ready=1; 0x99 never appears.
- Counter saturation with CNT_WIDTH=4: hold out_valid=1, out_ready=0 for 20 cycles → stall_count stops at 0xF and does not wrap.
- Reset asserted in TWO with out_ready=1 → no output transfer after the edge; all outputs at reset values.
